// File: rtl/one_hot_pkg.sv
// Shared definitions for one-hot sequencer consumers: lock FSM encoding,
// default state count and the index-width helper.
package one_hot_pkg;

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    CONFIRM = 2'd1,
    LOCKED  = 2'd2
  } lock_state_e;

  localparam int N_DEF = 4;

  // Index width for n states; never below 1 so N = 2 still gets a real bit.
  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/one_hot_decode.sv
// Combinational one-hot to binary encoder with an exactly-one-bit-set flag.
// The index is only meaningful when one is high.
module onehot_decode
  import one_hot_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int IDX_W = idx_w(N)
) (
  input  logic [N-1:0]     vec,
  output logic [IDX_W-1:0] idx,
  output logic             one
);

  logic seen;
  logic multi;

  always_comb begin
    idx   = '0;
    seen  = 1'b0;
    multi = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (vec[i]) begin
        multi = multi | seen;
        seen  = 1'b1;
        idx   = idx | IDX_W'(i);
      end
    end
    one = seen & ~multi;
  end

endmodule

// File: rtl/one_hot_seq_checker.sv
// Receive-side checker for a one-hot sequencer link: decodes the state vector,
// checks legality, ordering and the lagging code, tracks lock and counts errors.
module one_hot_seq_checker
  import one_hot_pkg::*;
#(
  parameter int N        = N_DEF,
  parameter int LOCK_CNT = 4,
  parameter int CNT_W    = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   valid_in,
  input  logic [N-1:0]           state_in,
  input  logic [idx_w(N)-1:0]    code_in,
  output logic [idx_w(N)-1:0]    dec_idx,
  output logic                   dec_valid,
  output logic                   onehot_err,
  output logic                   seq_err,
  output logic                   code_err,
  output logic                   locked,
  output logic [CNT_W-1:0]       err_count
);

  localparam int IDX_W = idx_w(N);
  localparam int CC_W  = idx_w(LOCK_CNT + 1);

  logic [IDX_W-1:0] samp_idx;
  logic             samp_one;

  onehot_decode #(
    .N     (N),
    .IDX_W (IDX_W)
  ) u_decode (
    .vec (state_in),
    .idx (samp_idx),
    .one (samp_one)
  );

  lock_state_e      state_q,      state_d;
  logic [CC_W-1:0]  cnt_q,        cnt_d;
  logic [IDX_W-1:0] ref_idx_q,    ref_idx_d;
  logic             ref_vld_q,    ref_vld_d;
  logic [IDX_W-1:0] dec_idx_q,    dec_idx_d;
  logic             dec_valid_q,  dec_valid_d;
  logic             onehot_err_q, onehot_err_d;
  logic             seq_err_q,    seq_err_d;
  logic             code_err_q,   code_err_d;
  logic             locked_q,     locked_d;
  logic [CNT_W-1:0] err_count_q,  err_count_d;

  logic [IDX_W-1:0] exp_idx;
  logic [CC_W-1:0]  cnt_inc;
  logic             any_err;

  always_comb begin
    exp_idx = (ref_idx_q == IDX_W'(N - 1)) ? '0 : ref_idx_q + 1'b1;
    cnt_inc = cnt_q + 1'b1;

    state_d      = state_q;
    cnt_d        = cnt_q;
    ref_idx_d    = ref_idx_q;
    ref_vld_d    = ref_vld_q;
    dec_idx_d    = dec_idx_q;
    err_count_d  = err_count_q;
    dec_valid_d  = 1'b0;
    onehot_err_d = 1'b0;
    seq_err_d    = 1'b0;
    code_err_d   = 1'b0;
    any_err      = 1'b0;

    if (valid_in) begin
      if (!samp_one) begin
        onehot_err_d = 1'b1;
      end else begin
        dec_idx_d   = samp_idx;
        dec_valid_d = 1'b1;
        // Always resynchronise the reference to the observed index.
        ref_idx_d   = samp_idx;
        ref_vld_d   = 1'b1;
        if (ref_vld_q) begin
          seq_err_d  = (samp_idx != exp_idx);
          code_err_d = (code_in != ref_idx_q);
        end
      end
      any_err = onehot_err_d | seq_err_d | code_err_d;

      unique case (state_q)
        HUNT: begin
          if (samp_one) begin
            cnt_d   = CC_W'(1);
            state_d = (LOCK_CNT == 1) ? LOCKED : CONFIRM;
          end
        end
        CONFIRM: begin
          if (!samp_one) begin
            cnt_d   = '0;
            state_d = HUNT;
          end else if (any_err) begin
            cnt_d = CC_W'(1);
          end else begin
            cnt_d = cnt_inc;
            if (cnt_inc == CC_W'(LOCK_CNT)) state_d = LOCKED;
          end
        end
        LOCKED: begin
          if (any_err) begin
            cnt_d   = '0;
            state_d = HUNT;
            if (err_count_q != {CNT_W{1'b1}}) err_count_d = err_count_q + 1'b1;
          end
        end
        default: begin
          cnt_d   = '0;
          state_d = HUNT;
        end
      endcase
    end

    locked_d = (state_d == LOCKED);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= HUNT;
      cnt_q        <= '0;
      ref_idx_q    <= '0;
      ref_vld_q    <= 1'b0;
      dec_idx_q    <= '0;
      dec_valid_q  <= 1'b0;
      onehot_err_q <= 1'b0;
      seq_err_q    <= 1'b0;
      code_err_q   <= 1'b0;
      locked_q     <= 1'b0;
      err_count_q  <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      ref_idx_q    <= ref_idx_d;
      ref_vld_q    <= ref_vld_d;
      dec_idx_q    <= dec_idx_d;
      dec_valid_q  <= dec_valid_d;
      onehot_err_q <= onehot_err_d;
      seq_err_q    <= seq_err_d;
      code_err_q   <= code_err_d;
      locked_q     <= locked_d;
      err_count_q  <= err_count_d;
    end
  end

  assign dec_idx    = dec_idx_q;
  assign dec_valid  = dec_valid_q;
  assign onehot_err = onehot_err_q;
  assign seq_err    = seq_err_q;
  assign code_err   = code_err_q;
  assign locked     = locked_q;
  assign err_count  = err_count_q;

endmodule

// File: tb/tb_one_hot_seq_checker.sv
// Directed vector bench for one_hot_seq_checker; a second instance with a
// 2-bit error counter shares the stimulus to exercise saturation.
module tb_one_hot_seq_checker;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       valid_in;
  logic [3:0] state_in;
  logic [1:0] code_in;

  logic [1:0] dec_idx, dec_idx2;
  logic       dec_valid, dec_valid2;
  logic       onehot_err, onehot_err2;
  logic       seq_err, seq_err2;
  logic       code_err, code_err2;
  logic       locked, locked2;
  logic [7:0] err_count;
  logic [1:0] err_count2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  one_hot_seq_checker #(.N(4), .LOCK_CNT(4), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .state_in(state_in),
    .code_in(code_in), .dec_idx(dec_idx), .dec_valid(dec_valid),
    .onehot_err(onehot_err), .seq_err(seq_err), .code_err(code_err),
    .locked(locked), .err_count(err_count)
  );

  one_hot_seq_checker #(.N(4), .LOCK_CNT(4), .CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .state_in(state_in),
    .code_in(code_in), .dec_idx(dec_idx2), .dec_valid(dec_valid2),
    .onehot_err(onehot_err2), .seq_err(seq_err2), .code_err(code_err2),
    .locked(locked2), .err_count(err_count2)
  );

  typedef struct {
    logic       v;
    logic [3:0] st;
    logic [1:0] cd;
    logic [1:0] idx;
    logic       dv, oh, sq, ce, lk;
    int         ec8;
    int         ec2;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic v, input logic [3:0] st, input logic [1:0] cd,
                     input logic [1:0] idx, input logic dv, input logic oh,
                     input logic sq, input logic ce, input logic lk,
                     input int ec8, input int ec2);
    vec_t e;
    e.v = v; e.st = st; e.cd = cd; e.idx = idx; e.dv = dv; e.oh = oh;
    e.sq = sq; e.ce = ce; e.lk = lk; e.ec8 = ec8; e.ec2 = ec2;
    tbl.push_back(e);
  endtask

  task automatic chk(input string name, input int row, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL row%0d %s: got %0d expected %0d", row, name, act, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " dec_idx"},    -1, int'(dec_idx),    0);
    chk({tag, " dec_valid"},  -1, int'(dec_valid),  0);
    chk({tag, " onehot_err"}, -1, int'(onehot_err), 0);
    chk({tag, " seq_err"},    -1, int'(seq_err),    0);
    chk({tag, " code_err"},   -1, int'(code_err),   0);
    chk({tag, " locked"},     -1, int'(locked),     0);
    chk({tag, " err_count"},  -1, int'(err_count),  0);
    chk({tag, " err_count2"}, -1, int'(err_count2), 0);
  endtask

  task automatic apply_reset();
    @(posedge clk);
    #2 rst_n = 1'b0;
    valid_in = 1'b0;
    #1 chk_zero("reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  localparam int RST_AT = 35;

  initial begin
    rst_n    = 1'b1;
    valid_in = 1'b0;
    state_in = '0;
    code_in  = '0;

    //   v  state    code idx dv oh sq ce lk ec8 ec2
    // clean lock with wrap
    add(1, 4'b0001, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    add(1, 4'b0010, 0, 1, 1, 0, 0, 0, 0, 0, 0);
    add(1, 4'b0100, 1, 2, 1, 0, 0, 0, 0, 0, 0);
    add(1, 4'b1000, 2, 3, 1, 0, 0, 0, 1, 0, 0);
    add(1, 4'b0001, 3, 0, 1, 0, 0, 0, 1, 0, 0);
    // illegal vector while locked, then relock
    add(1, 4'b0110, 0, 0, 0, 1, 0, 0, 0, 1, 1);
    add(1, 4'b0010, 0, 1, 1, 0, 0, 0, 0, 1, 1);
    add(1, 4'b0100, 1, 2, 1, 0, 0, 0, 0, 1, 1);
    add(1, 4'b1000, 2, 3, 1, 0, 0, 0, 0, 1, 1);
    add(1, 4'b0001, 3, 0, 1, 0, 0, 0, 1, 1, 1);
    // skip then code mismatch
    add(1, 4'b0010, 0, 1, 1, 0, 0, 0, 1, 1, 1);
    add(1, 4'b1000, 1, 3, 1, 0, 1, 0, 0, 2, 2);
    add(1, 4'b0001, 2, 0, 1, 0, 0, 1, 0, 2, 2);
    // gaps during confirm and while locked
    add(1, 4'b0010, 0, 1, 1, 0, 0, 0, 0, 2, 2);
    add(0, 4'b1111, 3, 1, 0, 0, 0, 0, 0, 2, 2);
    add(0, 4'b1111, 3, 1, 0, 0, 0, 0, 0, 2, 2);
    add(0, 4'b1111, 3, 1, 0, 0, 0, 0, 0, 2, 2);
    add(1, 4'b0100, 1, 2, 1, 0, 0, 0, 0, 2, 2);
    add(1, 4'b1000, 2, 3, 1, 0, 0, 0, 1, 2, 2);
    add(0, 4'b0110, 0, 3, 0, 0, 0, 0, 1, 2, 2);
    add(1, 4'b0001, 3, 0, 1, 0, 0, 0, 1, 2, 2);
    // zero-hot while locked, relock, simultaneous seq+code, relock, illegal
    add(1, 4'b0000, 0, 0, 0, 1, 0, 0, 0, 3, 3);
    add(1, 4'b0010, 0, 1, 1, 0, 0, 0, 0, 3, 3);
    add(1, 4'b0100, 1, 2, 1, 0, 0, 0, 0, 3, 3);
    add(1, 4'b1000, 2, 3, 1, 0, 0, 0, 0, 3, 3);
    add(1, 4'b0001, 3, 0, 1, 0, 0, 0, 1, 3, 3);
    add(1, 4'b0100, 3, 2, 1, 0, 1, 1, 0, 4, 3);
    add(1, 4'b1000, 2, 3, 1, 0, 0, 0, 0, 4, 3);
    add(1, 4'b0001, 3, 0, 1, 0, 0, 0, 0, 4, 3);
    add(1, 4'b0010, 0, 1, 1, 0, 0, 0, 0, 4, 3);
    add(1, 4'b0100, 1, 2, 1, 0, 0, 0, 1, 4, 3);
    add(1, 4'b1100, 0, 2, 0, 1, 0, 0, 0, 5, 3);
    // illegal in HUNT is flagged but not counted; two legal samples into CONFIRM
    add(1, 4'b1001, 0, 2, 0, 1, 0, 0, 0, 5, 3);
    add(1, 4'b1000, 2, 3, 1, 0, 0, 0, 0, 5, 3);
    add(1, 4'b0001, 3, 0, 1, 0, 0, 0, 0, 5, 3);
    // after mid-CONFIRM reset: first sample unchecked, lock needs 4 fresh samples
    add(1, 4'b0100, 0, 2, 1, 0, 0, 0, 0, 0, 0);
    add(1, 4'b1000, 2, 3, 1, 0, 0, 0, 0, 0, 0);
    add(1, 4'b0001, 3, 0, 1, 0, 0, 0, 0, 0, 0);
    add(1, 4'b0010, 0, 1, 1, 0, 0, 0, 1, 0, 0);

    repeat (2) @(posedge clk);
    apply_reset();

    for (int r = 0; r < tbl.size(); r++) begin
      if (r == RST_AT) apply_reset();
      @(negedge clk);
      valid_in = tbl[r].v;
      state_in = tbl[r].st;
      code_in  = tbl[r].cd;
      @(posedge clk);
      #1;
      chk("dec_idx",    r, int'(dec_idx),    int'(tbl[r].idx));
      chk("dec_valid",  r, int'(dec_valid),  int'(tbl[r].dv));
      chk("onehot_err", r, int'(onehot_err), int'(tbl[r].oh));
      chk("seq_err",    r, int'(seq_err),    int'(tbl[r].sq));
      chk("code_err",   r, int'(code_err),   int'(tbl[r].ce));
      chk("locked",     r, int'(locked),     int'(tbl[r].lk));
      chk("err_count",  r, int'(err_count),  tbl[r].ec8);
      chk("err_count2", r, int'(err_count2), tbl[r].ec2);
    end

    @(negedge clk);
    valid_in = 1'b0;
    @(posedge clk);
    #1;
    chk("idle dec_valid", -1, int'(dec_valid), 0);
    chk("idle locked",    -1, int'(locked),    1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/one_hot_seq_checker.md
Name: one_hot_seq_checker

Overview:
- Receive-side decoder and checker for a registered one-hot sequencer interface.
- Input per sample: an N-bit one-hot state vector plus a binary code.
- The code carries the index of the previous state, so it lags the state vector by one sample.
- Decodes the vector to a binary index, checks one-hot legality, sequence order and code consistency, tracks lock, and counts errors. Sits at the consumer end of the link.

Parameters:
- N, 4, number of states (one-hot width), N ≥ 2.
- LOCK_CNT, 4, consecutive legal samples needed to declare lock, ≥ 1.
- CNT_W, 8, width of the saturating error counter.
- IDX_W, derived localparam = clog2(N), index and code width.

Ports:
- clk, in, 1, rising-edge clock.
- rst_n, in, 1, asynchronous active-low reset.
- valid_in, in, 1, sample qualifier.
- state_in, in, N, one-hot state vector.
- code_in, in, IDX_W, binary index of the previous sample's state.
- dec_idx, out, IDX_W, decoded index of the last legal sample.
- dec_valid, out, 1, one-cycle pulse: dec_idx updated this cycle.
- onehot_err, out, 1, pulse: last sample was not exactly one-hot.
- seq_err, out, 1, pulse: last sample was not the successor of the reference index.
- code_err, out, 1, pulse: code_in did not match the reference index.
- locked, out, 1, level: lock FSM is in LOCKED.
- err_count, out, CNT_W, saturating count of error samples seen while LOCKED.

Behaviour:
- Reset (rst_n low, asynchronous):
  - All outputs are 0.
  - FSM goes to HUNT; confirm counter is 0; reference-valid flag is 0.
- Timing:
  - All outputs are registered; latency is 1 clk from the sampling edge.
  - Pulses last exactly 1 cycle.
- valid_in = 0:
  - No checks are made; pulses deassert.
  - FSM, reference index, counters and dec_idx hold.
  - Gaps do not break sequence continuity.
- For each valid sample, with ref_idx/ref_vld as the reference register:
  - Legal sample: popcount(state_in) == 1.
    - dec_idx ← its index; dec_valid = 1.
  - Illegal sample: onehot_err = 1, and seq_err and code_err are forced to 0.
    - dec_idx and the reference register are unchanged.
  - Legal sample with ref_vld = 1:
    - seq_err = 1 if idx ≠ (ref_idx + 1) mod N. Wrap: index N−1 → 0 is legal.
    - code_err = 1 if code_in ≠ ref_idx.
  - Legal sample with ref_vld = 0: no sequence or code check.
  - A legal sample always updates ref_idx ← idx and sets ref_vld ← 1, even when seq_err or code_err fires, so the checker resynchronises.
- Error sample: any of onehot_err, seq_err or code_err set.
- Lock FSM (2-bit binary state; confirm counter sized for LOCK_CNT):
  - HUNT:
    - Legal sample → CONFIRM with cnt = 1.
    - If LOCK_CNT == 1, go straight to LOCKED.
  - CONFIRM:
    - Legal, error-free sample → cnt + 1; when cnt reaches LOCK_CNT → LOCKED.
    - Legal sample with seq_err or code_err → stay in CONFIRM with cnt = 1.
    - onehot_err → HUNT with cnt = 0.
  - LOCKED:
    - Error sample → HUNT, and err_count increments, saturating at 2^CNT_W − 1.
    - Clean samples stay in LOCKED.
  - locked is high in the cycle after the transition edge into LOCKED.
  - Errors outside LOCKED are flagged but not counted.
- err_count is cleared only by reset.
- Simultaneous seq_err and code_err count as one error sample: increment by 1.
- Reset mid-operation clears everything, including err_count. The next legal sample is unchecked.

Decomposition:
- Shared package one_hot_pkg:
  - Lock FSM state encoding: HUNT = 0, CONFIRM = 1, LOCKED = 2.
  - Default N.
  - The clog2-based IDX_W helper.
- One sub-module, onehot_decode: combinational N → IDX_W index encoder plus an exactly-one flag. It is reusable by the team's other one-hot consumers.

Test Plan:
- Reset:
  - rst_n low for 2 cycles, mid-clock → all outputs 0 immediately, locked = 0, err_count = 0.
- Clean lock:
  - Stimulus: valid stream state_in 0001, 0010, 0100, 1000, 0001 with code_in 00, 00, 01, 10, 11.
  - Response: dec_idx 0, 1, 2, 3, 0; no error pulses; locked rises 1 cycle after the 4th sample; wrap 3 → 0 raises no error.
- Illegal vector while locked:
  - Stimulus: 0110.
  - Response: onehot_err pulses; seq_err = 0, code_err = 0; dec_idx holds; locked drops; err_count = 1.
  - Then 4 clean successors → relock.
- Skip and code mismatch:
  - Stimulus while locked: 0010 followed by 1000 with correct code 01.
  - Response: seq_err = 1 only, and ref resyncs to 3.
  - Then 0001 with code 10 → code_err = 1 only.
  - err_count increments once, since the second error arrives while in HUNT/CONFIRM.
- Gaps and saturation:
  - Stimulus: valid_in low for 3 cycles mid-sequence.
  - Response: no pulses and the sequence continues cleanly.
  - With CNT_W = 2, force 5 locked errors (relocking each time) → err_count sticks at 3.
- Reset mid-CONFIRM:
  - Stimulus: assert rst_n low after 2 legal samples.
  - Response: FSM in HUNT. The first sample after release (e.g. 0100, code 00) raises no seq_err or code_err.
